// File: rtl/go_highlight_anim.sv
// rtl/go_highlight_anim.sv - winning-line highlight: latch, sweep along line(s), then blink
module go_highlight_anim #(
    parameter int                 N         = 3,
    parameter int                 CW        = 2,
    parameter int                 COLOR_W   = 12,
    parameter logic [COLOR_W-1:0] WIN_COLOR = 12'h0F0,
    parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h000,
    parameter int                 STEP_CYC  = 12_500_000,
    parameter int                 BLINK_CYC = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 game_over,
    input  logic [2*N+1:0]       win_lines,
    input  logic                 clr,
    input  logic [2*CW-1:0]      addr,
    output logic [COLOR_W-1:0]   color,
    output logic                 anim_busy
);

    localparam int CNT_MAX = (STEP_CYC > BLINK_CYC) ? STEP_CYC : BLINK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STEP_T  = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_T = CNT_W'(BLINK_CYC - 1);
    localparam logic [CW:0]      N_V     = (CW+1)'(N);
    localparam logic [CW-1:0]    LAST    = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        BLINK = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [2*N+1:0]     lines, lines_nxt;
    logic [CW-1:0]      step, step_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               phase, phase_nxt;

    logic [CW-1:0]      row, col;
    logic               in_range, row_hit, col_hit, diag_hit, anti_hit;
    logic               on_line, sweep_lit, lit;
    logic [COLOR_W-1:0] color_nxt;

    assign row = addr[2*CW-1:CW];
    assign col = addr[CW-1:0];

    // Cell decode against the latched line set; position is col for rows, row otherwise.
    always_comb begin
        row_hit = 1'b0;
        col_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (row == CW'(i)) row_hit = lines[i];
            if (col == CW'(i)) col_hit = lines[N+i];
        end
        in_range  = ({1'b0, row} < N_V) && ({1'b0, col} < N_V);
        diag_hit  = lines[2*N] && (row == col);
        anti_hit  = lines[2*N+1] && (({1'b0, row} + {1'b0, col}) == (N_V - 1'b1));
        on_line   = row_hit || col_hit || diag_hit || anti_hit;
        sweep_lit = (row_hit && (col <= step)) ||
                    ((col_hit || diag_hit || anti_hit) && (row <= step));
        lit = 1'b0;
        case (state)
            SWEEP:   lit = sweep_lit;
            BLINK:   lit = on_line && phase;
            default: lit = 1'b0;
        endcase
        color_nxt = (lit && in_range) ? WIN_COLOR : BG_COLOR;
    end

    always_comb begin
        state_nxt = state;
        lines_nxt = lines;
        step_nxt  = step;
        cnt_nxt   = cnt;
        phase_nxt = phase;
        if (clr || !game_over) begin
            state_nxt = IDLE;
            lines_nxt = '0;
            step_nxt  = '0;
            cnt_nxt   = '0;
            phase_nxt = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|win_lines) begin
                        state_nxt = SWEEP;
                        lines_nxt = win_lines;
                        step_nxt  = '0;
                        cnt_nxt   = '0;
                    end
                end
                SWEEP: begin
                    if (cnt == STEP_T) begin
                        cnt_nxt = '0;
                        if (step == LAST) begin
                            state_nxt = BLINK;
                            phase_nxt = 1'b1;
                        end else begin
                            step_nxt = step + CW'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                BLINK: begin
                    if (cnt == BLINK_T) begin
                        cnt_nxt   = '0;
                        phase_nxt = ~phase;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            lines <= '0;
            step  <= '0;
            cnt   <= '0;
            phase <= 1'b1;
            color <= BG_COLOR;
        end else begin
            state <= state_nxt;
            lines <= lines_nxt;
            step  <= step_nxt;
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
            color <= color_nxt;
        end
    end

    assign anim_busy = (state == SWEEP);

endmodule

// File: doc/go_highlight_anim.md
Name: go_highlight_anim

Overview:
- Parametrised successor of the combinational winning-line colour decoder in the game display path.
- Supports an N×N board with configurable colours.
- On a win, it latches the winning line(s), animates them as a sweep along the line, then blinks them until the game-over condition clears.
- Sits between the game-state logic and the VGA pixel colour mux, and is addressed per board cell.

Parameters:
- N, 3, board dimension (N×N cells), legal range 3..8.
- CW, 2, cell-coordinate width per axis, must satisfy 2^CW ≥ N.
- COLOR_W, 12, colour word width.
- WIN_COLOR, 12'h0F0, colour of a lit winning cell.
- BG_COLOR, 12'h000, colour otherwise.
- STEP_CYC, 12_500_000, clock cycles per sweep step, ≥ 1.
- BLINK_CYC, 25_000_000, clock cycles per blink half-period, ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- game_over  in  1  game finished (win or draw), level.
- win_lines  in  2N+2  winning-line flags. Bits [N-1:0] are rows 0..N-1, [2N-1:N] are columns 0..N-1, [2N] is the main diagonal (r==c), [2N+1] is the anti-diagonal (r+c==N-1).
- clr  in  1  new-game pulse, forces IDLE.
- addr  in  2*CW  cell address {row[CW-1:0], col[CW-1:0]}.
- color  out  COLOR_W  registered cell colour.
- anim_busy  out  1  high in SWEEP.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset state: state=IDLE, latched lines L=0, step=0, cycle counter=0, phase=1, color=BG_COLOR, anim_busy=0.
- Latency: color at edge t+1 is a function of addr and state/L/step/phase as sampled at edge t (1-cycle latency).
- Cell-on-line test: cell (r,c) is on L when any of these hold: L[r], L[N+c], (L[2N] & r==c), (L[2N+1] & r+c==N-1).
- Position along line: c for a row line, r for every other line. If the cell lies on several latched lines, it is lit if any qualifying line lights it.
- Out-of-range address (r≥N or c≥N): BG_COLOR always.
- IDLE:
  - color=BG.
  - If game_over & |win_lines: L<=win_lines, step<=0, counter<=0, go to SWEEP.
  - If game_over & ~|win_lines (draw): remain IDLE.
- SWEEP:
  - anim_busy=1.
  - Lit iff the cell is on L with position ≤ step.
  - Counter counts 0..STEP_CYC-1. At terminal count: if step<N-1 then step++, else go to BLINK with phase=1 and counter=0.
- BLINK:
  - Lit iff the cell is on L and phase=1.
  - Counter counts 0..BLINK_CYC-1 and toggles phase at terminal count.
  - Remains in BLINK indefinitely while game_over=1.
- Changes to win_lines after latching are ignored until the block returns to IDLE.
- Exit: ~game_over or clr in any state → IDLE next edge, L<=0, counters cleared. Clr takes priority over the IDLE capture in the same cycle. game_over that is still high after a clr re-triggers capture on the following cycle.
- Reset mid-animation: returns to the reset state at the next edge. No residual lit cells.
- Counters: width clog2(max(STEP_CYC,BLINK_CYC)). They wrap only via explicit terminal-count clear; no overflow is possible.
- Lit colour is WIN_COLOR, otherwise BG_COLOR.

Test Plan:
All cases use N=3, CW=2, STEP_CYC=4, BLINK_CYC=8.

1. Reset and idle decode.
   - Stimulus: rst_n=0 for 2 cycles, then release with game_over=0; sweep addr through 0x0..0xF.
   - Required response: color=12'h000 on every cycle; anim_busy=0.
2. Row sweep.
   - Stimulus: game_over=1, win_lines=8'b0000_0010 (row 1).
   - Required response:
     - 1 cycle later, state=SWEEP and anim_busy=1.
     - During step 0, addr 0x4 gives 0F0 while 0x5 and 0x6 give 000.
     - After 4 cycles 0x5 is lit; after 8 cycles 0x6 is lit.
     - After 12 cycles the block is in BLINK and all three cells are lit.
     - Cells then toggle every 8 cycles.
3. Double win and diagonal.
   - Stimulus: win_lines=8'b1100_0000 (both diagonals).
   - Required response:
     - 0x5 is lit from step 1 onward.
     - 0x0 and 0x2 are lit at step 0; 0x8 and 0xA are lit at step 2.
     - 0x1 is never lit.
4. Draw.
   - Stimulus: game_over=1, win_lines=0 for 100 cycles.
   - Required response: state stays IDLE; color=000 for every addr.
5. Abort and clr.
   - Stimulus (part 1): drop game_over mid-SWEEP at step 1.
   - Required response (part 1): next cycle is IDLE with color=000.
   - Stimulus (part 2): in BLINK, pulse clr for 1 cycle while game_over=1 and win_lines=row 0.
   - Required response (part 2): 1 cycle in IDLE, then re-capture into SWEEP with step=0.
6. Latch hold and out-of-range.
   - Stimulus: during BLINK, change win_lines to col 2; apply addr 0x3, 0xC and 0xF.
   - Required response:
     - The lit cells remain those of the originally latched line.
     - Addr 0x3, 0xC and 0xF always give 000.
